ifns_decode_arbiter: RTL and testbench

Shares one Fibonacci-weighted (IFNS) 16-wire-to-value decode datapath among `NUM_LANES` independent receive lanes of the crosstalk-avoidance link. Each lane presents a 16-bit codeword with a valid/ready handshake. A round-robin arbiter grants one lane per cycle. The decoded value is registered and tagged with the source lane, with an overflow flag when the weighted sum exceeds the 11-bit value range. The block sits between the lane deserializers and the downstream word sink.

---
 rtl/ifns_decode_arbiter.sv | 120 ++++++++++++
 tb/tb_ifns_decode_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ifns_decode_arbiter.sv
// Round-robin arbiter sharing one IFNS (Fibonacci-weighted) 16-wire decoder
// among NUM_LANES receive lanes, with a one-entry registered output stage.
module ifns_decode_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_LANES-1:0]    in_valid,
  input  logic [16*NUM_LANES-1:0] in_data,
  output logic [NUM_LANES-1:0]    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [10:0]             out_value,
  output logic                    out_ovf,
  output logic [LANE_W-1:0]       out_lane,
  output logic [15:0]             word_count
);

  // Weight of wire d1..d16; the sequence skips 987 before the top wire.
  localparam logic [11:0] WEIGHTS [16] = '{
    12'd1,   12'd1,   12'd2,   12'd3,   12'd5,   12'd8,   12'd13,  12'd21,
    12'd34,  12'd55,  12'd89,  12'd144, 12'd233, 12'd377, 12'd610, 12'd1597
  };

  function automatic logic [11:0] ifns_decode(input logic [15:0] cw);
    logic [11:0] sum;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      if (cw[i]) sum = sum + WEIGHTS[i];
    end
    return sum;
  endfunction

  logic [LANE_W-1:0] rr_q, rr_d;
  logic              out_valid_q;
  logic [10:0]       value_q;
  logic              ovf_q;
  logic [LANE_W-1:0] lane_q;
  logic [15:0]       count_q;

  logic              can_accept;
  logic              found_hi, found_lo;
  logic [LANE_W-1:0] hi_idx, lo_idx, gnt_idx;
  logic              grant;
  logic [15:0]       gnt_cw;
  logic [11:0]       gnt_sum;
  logic              out_hs;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    found_hi   = 1'b0;
    found_lo   = 1'b0;
    hi_idx     = '0;
    lo_idx     = '0;
    // Descending scan so the lowest index in each half overwrites last.
    for (int j = NUM_LANES - 1; j >= 0; j--) begin
      if (in_valid[j]) begin
        if (LANE_W'(j) >= rr_q) begin
          found_hi = 1'b1;
          hi_idx   = LANE_W'(j);
        end else begin
          found_lo = 1'b1;
          lo_idx   = LANE_W'(j);
        end
      end
    end
    gnt_idx = found_hi ? hi_idx : lo_idx;
    grant   = (found_hi || found_lo) && can_accept && rst_n;

    in_ready = '0;
    gnt_cw   = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (LANE_W'(j) == gnt_idx) begin
        in_ready[j] = grant;
        gnt_cw      = in_data[16*j +: 16];
      end
    end
    gnt_sum = ifns_decode(gnt_cw);

    rr_d = rr_q;
    if (grant) rr_d = (gnt_idx == LANE_W'(NUM_LANES - 1)) ? '0 : gnt_idx + 1'b1;

    out_hs = out_valid_q && out_ready;
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // pre-edge values; the output stage has only one entry, so every register
  // is reset, not just the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      value_q     <= '0;
      ovf_q       <= 1'b0;
      lane_q      <= '0;
      count_q     <= '0;
    end else begin
      rr_q <= rr_d;
      if (grant) begin
        out_valid_q <= 1'b1;
        value_q     <= gnt_sum[10:0];
        ovf_q       <= gnt_sum[11];
        lane_q      <= gnt_idx;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
      if (out_hs) count_q <= count_q + 16'd1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_value  = value_q;
  assign out_ovf    = ovf_q;
  assign out_lane   = lane_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_ifns_decode_arbiter.sv
// Randomized and directed bench for ifns_decode_arbiter against a behavioural
// model of round-robin grant, Fibonacci-weighted decode and output register.
module tb_ifns_decode_arbiter;

  localparam int N = 4;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [16*N-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [10:0]     out_value;
  logic            out_ovf;
  logic [LW-1:0]   out_lane;
  logic [15:0]     word_count;

  ifns_decode_arbiter #(.NUM_LANES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_ovf(out_ovf), .out_lane(out_lane),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_ptr, m_value, m_lane, m_count;
  bit m_valid, m_ovf;

  task automatic model_reset();
    m_ptr = 0; m_value = 0; m_lane = 0; m_count = 0; m_valid = 0; m_ovf = 0;
  endtask

  // Weight of wire d(i+1): Fibonacci numbers F1..F15, then F17 for d16.
  function automatic int ifns_weight(input int i);
    int a, b, t, n;
    a = 1; b = 1;
    n = (i == 15) ? 17 : i + 1;
    for (int k = 2; k < n; k++) begin
      t = a + b; a = b; b = t;
    end
    return (n <= 2) ? 1 : b;
  endfunction

  function automatic int ref_sum(input logic [15:0] cw);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) if (cw[i]) s += ifns_weight(i);
    return s;
  endfunction

  function automatic logic [15:0] lane_cw(input logic [16*N-1:0] d, input int k);
    return d[16*k +: 16];
  endfunction

  // One clock: check at negedge against the model, then advance the model.
  task automatic step(input bit do_chk);
    int g, idx, s;
    bit hs;
    logic [15:0] cw;
    @(negedge clk);
    g = -1;
    if (!m_valid || out_ready) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && in_valid[idx]) g = idx;
      end
    end
    cw = (g >= 0) ? lane_cw(in_data, g) : 16'h0;
    if (do_chk) begin
      check("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_value", 32'(out_value), m_value);
      check("out_ovf", 32'(out_ovf), 32'(m_ovf));
      check("out_lane", 32'(out_lane), m_lane);
      check("word_count", 32'(word_count), m_count);
    end
    hs = m_valid && out_ready;
    @(posedge clk);
    if (hs) m_count = (m_count + 1) % 65536;
    if (g >= 0) begin
      s = ref_sum(cw);
      m_valid = 1; m_value = s % 2048; m_ovf = (s > 2047); m_lane = g;
      m_ptr = (g + 1) % N;
    end else if (hs) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_lane(input int k, input logic [15:0] cw);
    in_data[16*k +: 16] = cw;
  endtask

  initial begin
    logic [15:0] cws [3];
    int exp_vals [3];
    cws = '{16'h0001, 16'h8000, 16'h5555};
    exp_vals = '{1, 1597, 987};

    rst_n = 1'b0; in_valid = '1; in_data = {$urandom, $urandom}; out_ready = 1'b1;
    model_reset();
    #3;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_word_count", 32'(word_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Skip idle lanes: only lane 3 valid with pointer at 0
    in_valid = 4'b1000; set_lane(3, 16'h0003);
    #1 check("skip_rdy", 32'(in_ready), 32'b1000);
    step(1);
    check("skip_lane", 32'(out_lane), 3);
    check("skip_value", 32'(out_value), 2);
    in_valid = 4'b1001; set_lane(0, 16'h0000);
    #1 check("skip_ptr_wrap", 32'(in_ready), 32'b0001);
    step(1);
    in_valid = '0; step(1);

    // Single decodes on lane 0
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0001; set_lane(0, cws[i]);
      step(1);
      check("dec_valid", 32'(out_valid), 1);
      check("dec_value", 32'(out_value), exp_vals[i]);
      check("dec_ovf", 32'(out_ovf), 0);
      check("dec_lane", 32'(out_lane), 0);
    end
    in_valid = '0; step(1);
    check("dec_count", 32'(word_count), 5);

    // Overflow
    in_valid = 4'b0001; set_lane(0, 16'hFFFF);
    step(1);
    check("ovf_value", 32'(out_value), 1145);
    check("ovf_flag", 32'(out_ovf), 1);
    in_valid = '0; step(1);

    // Mid-stream asynchronous reset
    in_valid = '1; in_data = {$urandom, $urandom};
    repeat (3) step(1);
    rst_n = 1'b0;
    #2;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_value", 32'(out_value), 0);
    check("arst_ovf", 32'(out_ovf), 0);
    check("arst_lane", 32'(out_lane), 0);
    check("arst_count", 32'(word_count), 0);
    check("arst_ready", 32'(in_ready), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin fairness, first word after release from lane 0
    for (int i = 0; i < 8; i++) begin
      in_data = {$urandom, $urandom};
      step(1);
      check("rr_lane", 32'(out_lane), i % N);
      check("rr_valid", 32'(out_valid), 1);
    end
    in_valid = '0; step(1);

    // Backpressure: lanes 1 and 2, sink stalled after the first word
    in_valid = 4'b0110; set_lane(1, 16'h1234); set_lane(2, 16'h0F0F);
    step(1);
    check("bp_first_lane", 32'(out_lane), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_hold_lane", 32'(out_lane), 1);
      check("bp_hold_value", 32'(out_value), ref_sum(16'h1234) % 2048);
      check("bp_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_rdy", 32'(in_ready), 32'b0100);
    step(1);
    check("bp_release_lane", 32'(out_lane), 2);
    check("bp_release_valid", 32'(out_valid), 1);
    in_valid = '0; step(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = N'($urandom);
      in_data = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) set_lane($urandom_range(0, N - 1), 16'hFFFF);
      out_ready = ($urandom_range(0, 9) < 7);
      step(1);
    end

    // word_count wrap
    rst_n = 1'b0; #2; model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    in_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) step(0);
    check("wrap_pre", 32'(word_count), 65535);
    step(1);
    check("wrap_zero", 32'(word_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
